muldiv_hilo: RTL and testbench
==============================

# muldiv_hilo

Execute-stage multiply/divide unit with the architectural HI/LO register pair for the MIPS pipeline. It consumes the 8-bit ALU operation code produced in decode and carried into execute, and acts on MULT, MULTU, DIV, DIVU, MTHI and MTLO. It stalls the pipeline while a multi-cycle operation is in flight and exposes HI/LO for MFHI/MFLO. Single-cycle ALU ops are ignored here and handled by the main ALU.

## Interface
- No parameters; widths fixed (32-bit operands, 64-bit result).
- `clk` in 1: single clock; all state updates on rising edge.
- `resetn` in 1: reset, asynchronous, active-low.
- `alucontrolE` in 8: operation code in execute, using the `EXE_*_OP` codes from `defines.vh`.
- `validE` in 1: execute stage holds a real instruction, not a bubble.
- `flushE` in 1: cancel the in-flight operation and the current instruction.
- `srcaE` in 32: rs operand; dividend or multiplicand; MTHI/MTLO data.
- `srcbE` in 32: rt operand; divisor or multiplier.
- `stallE` out 1: hold the pipeline; instruction in execute is frozen.
- `hi_o` out 32: HI register value.
- `lo_o` out 32: LO register value.

## Operation
- States:
  - IDLE: accepts operations.
  - BUSY: iterating, with a 5-bit counter.
  - DONE: result is written.
- Start condition: IDLE, validE=1, flushE=0, and alucontrolE is one of MULT, MULTU, DIV or DIVU (MULT/MULTU only when `MULDIV_ITER_MULT_EN` is defined).
  - Latch the op, signed flag and operands.
  - Go to BUSY; the counter is set to 0.
- Signed ops (MULT, DIV):
  - Operate on absolute values.
  - Product sign is the XOR of the operand signs.
  - Quotient sign is the XOR of the operand signs.
  - Remainder takes the sign of the dividend.
  - Sign correction is applied when entering DONE.
- Divide: restoring, 1 quotient bit per cycle, 32 iterations, counter 0..31.
- Divide by zero: no exception. LO=0xFFFFFFFF, HI=srcaE, for both DIV and DIVU.
- Result placement: MULT/MULTU put product[63:32] in HI and product[31:0] in LO. DIV/DIVU put the quotient in LO and the remainder in HI.
- BUSY: when counter=31, go to DONE.
- DONE: HI/LO written on the edge leaving DONE; the state then returns to IDLE. New starts are ignored in DONE.
- MTHI/MTLO: in IDLE with validE=1 and flushE=0, write srcaE to HI or LO on that edge.
- MFHI/MFLO: no action here; `hi_o`/`lo_o` are continuous register outputs.
- While busy, alucontrolE/srcaE/srcbE are ignored; the latched copies are used.
- flushE=1 in any state:
  - Next state is IDLE.
  - No HI/LO write, including in DONE and for MTHI/MTLO.
  - Flush beats start in the same cycle.

## Timing
- Reset values: state IDLE, counter 0, stallE=0, hi_o=0, lo_o=0, all latched operands 0.
- A reset asserted mid-operation clears everything immediately, without waiting for an edge.
- stallE is combinational:
  - High in the start cycle (IDLE plus start condition).
  - High throughout BUSY.
  - Low in IDLE (non-start) and in DONE.
  - Forced low when flushE=1.
- Divide and iterative multiply, with cycle 0 as the start cycle:
  - BUSY spans cycles 1–32; DONE is cycle 33.
  - stallE is high for 33 cycles (0–32).
  - New HI/LO are visible from cycle 34.
  - The instruction leaves execute at the end of cycle 33.
- Back-to-back: a second DIV enters execute in cycle 34, with state IDLE, and starts immediately. There are no dead cycles beyond DONE.
- MTHI/MTLO: 1 cycle, no stall. The value is visible on `hi_o`/`lo_o` the next cycle.

## Configuration
- `MULDIV_ITER_MULT_EN` defined:
  - MULT/MULTU use a 32-cycle shift-add datapath sharing the divider's counter and adder.
  - Timing is identical to divide.
- `MULDIV_ITER_MULT_EN` undefined:
  - MULT/MULTU use a combinational 64-bit multiplier.
  - HI/LO are written on the edge ending the issue cycle (IDLE, validE=1, flushE=0).
  - No stall; the FSM is not entered.

## Test plan
- DIV, srcaE=0xFFFFFFF9 (−7), srcbE=2 -> stallE high exactly 33 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU, srcaE=0xFFFFFFFF, srcbE=0x10 -> LO=0x0FFFFFFF, HI=0x0000000F. Then an immediate second DIVU 100/7 -> LO=14, HI=2, with no extra idle cycle.
- MULT 0xFFFFFFFF×2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU with the same operands -> HI=0x1, LO=0xFFFFFFFE.
  - Check with the macro defined: 33-cycle stall.
  - Check with the macro undefined: no stall, result next cycle.
- DIV by zero, srcaE=0x1234, srcbE=0 -> LO=0xFFFFFFFF, HI=0x1234, normal 33-cycle latency.
- flushE pulsed at cycle 10 of a DIV -> stallE low in that cycle, IDLE next cycle, HI/LO unchanged.
  - Also: flushE in DONE -> no write. flushE with MTHI 0xA5A5A5A5 -> HI unchanged.
- Preload HI=LO=0xDEADBEEF via MTHI/MTLO, start a DIV, drop resetn at cycle 5 -> stallE, hi_o and lo_o become 0 immediately. After release, a new DIV completes correctly.

Source files
------------

// File: rtl/muldiv_hilo.sv
// Execute-stage multiply/divide unit owning the HI/LO register pair.
// Define MULDIV_ITER_MULT_EN to run MULT/MULTU on the shared iterative datapath.
module muldiv_hilo (
   input  logic        clk,
   input  logic        resetn,
   input  logic [7:0]  alucontrolE,
   input  logic        validE,
   input  logic        flushE,
   input  logic [31:0] srcaE,
   input  logic [31:0] srcbE,
   output logic        stallE,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   localparam logic [7:0] EXE_MTHI_OP  = 8'b00010001;
   localparam logic [7:0] EXE_MTLO_OP  = 8'b00010011;
   localparam logic [7:0] EXE_MULT_OP  = 8'b00011000;
   localparam logic [7:0] EXE_MULTU_OP = 8'b00011001;
   localparam logic [7:0] EXE_DIV_OP   = 8'b00011010;
   localparam logic [7:0] EXE_DIVU_OP  = 8'b00011011;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      state, state_nxt;
   logic [4:0]  cnt;
   logic        is_mul, neg_q, neg_r, dz;
   logic [31:0] a_lat, opnd;
   logic [63:0] acc;
   logic [31:0] hi_q, lo_q;

   logic        is_div_op, is_mul_op, sgn_op, issue, start;
   logic [31:0] a_abs, b_abs;

   assign is_div_op = (alucontrolE == EXE_DIV_OP) || (alucontrolE == EXE_DIVU_OP);
   assign is_mul_op = (alucontrolE == EXE_MULT_OP) || (alucontrolE == EXE_MULTU_OP);
   assign sgn_op    = (alucontrolE == EXE_MULT_OP) || (alucontrolE == EXE_DIV_OP);
   assign issue     = (state == IDLE) && validE && !flushE;

`ifdef MULDIV_ITER_MULT_EN
   assign start = issue && (is_div_op || is_mul_op);
`else
   logic signed [63:0] prod_s;
   logic        [63:0] prod_u;
   assign start  = issue && is_div_op;
   assign prod_s = $signed(srcaE) * $signed(srcbE);
   assign prod_u = {32'b0, srcaE} * {32'b0, srcbE};
`endif

   assign a_abs = (sgn_op && srcaE[31]) ? (~srcaE + 32'd1) : srcaE;
   assign b_abs = (sgn_op && srcbE[31]) ? (~srcbE + 32'd1) : srcbE;

   // one 34-bit adder serves both the shift-add and the trial subtract
   logic [32:0] rem_sh;
   logic [33:0] add_x, add_y, add_s;
   logic        add_ci;
   logic [63:0] acc_step, acc_fix;
   logic [31:0] q_t, r_t;

   assign rem_sh = {acc[63:32], acc[31]};

   always_comb begin
      add_x  = {1'b0, rem_sh};
      add_y  = ~{2'b0, opnd};
      add_ci = 1'b1;
      if (is_mul) begin
         add_x  = {2'b0, acc[63:32]};
         add_y  = {2'b0, acc[0] ? opnd : 32'b0};
         add_ci = 1'b0;
      end
   end

   assign add_s = add_x + add_y + {33'b0, add_ci};

   always_comb begin
      acc_step = {add_s[31:0], acc[30:0], 1'b1};
      if (is_mul)
         acc_step = {add_s[32:0], acc[31:1]};
      else if (add_s[33])
         acc_step = {rem_sh[31:0], acc[30:0], 1'b0};
   end

   always_comb begin
      q_t     = neg_q ? (~acc_step[31:0] + 32'd1) : acc_step[31:0];
      r_t     = neg_r ? (~acc_step[63:32] + 32'd1) : acc_step[63:32];
      acc_fix = {r_t, q_t};
      if (is_mul)
         acc_fix = neg_q ? (~acc_step + 64'd1) : acc_step;
      else if (dz)
         acc_fix = {a_lat, 32'hFFFF_FFFF};
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = BUSY;
         BUSY:    if (cnt == 5'd31) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (flushE) state_nxt = IDLE;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state  <= IDLE;
         cnt    <= 5'd0;
         is_mul <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         dz     <= 1'b0;
         a_lat  <= 32'b0;
         opnd   <= 32'b0;
         acc    <= 64'b0;
      end else begin
         state <= state_nxt;
         if (start) begin
            cnt    <= 5'd0;
            is_mul <= is_mul_op;
            neg_q  <= sgn_op && (srcaE[31] ^ srcbE[31]);
            neg_r  <= sgn_op && srcaE[31];
            dz     <= is_div_op && (srcbE == 32'b0);
            a_lat  <= srcaE;
            opnd   <= is_mul_op ? a_abs : b_abs;
            acc    <= {32'b0, is_mul_op ? b_abs : a_abs};
         end else if (state == BUSY && !flushE) begin
            cnt <= cnt + 5'd1;
            acc <= (cnt == 5'd31) ? acc_fix : acc_step;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hi_q <= 32'b0;
         lo_q <= 32'b0;
      end else if (state == DONE && !flushE) begin
         hi_q <= acc[63:32];
         lo_q <= acc[31:0];
      end else if (issue) begin
         if (alucontrolE == EXE_MTHI_OP) hi_q <= srcaE;
         if (alucontrolE == EXE_MTLO_OP) lo_q <= srcaE;
`ifndef MULDIV_ITER_MULT_EN
         if (alucontrolE == EXE_MULT_OP) begin
            hi_q <= prod_s[63:32];
            lo_q <= prod_s[31:0];
         end
         if (alucontrolE == EXE_MULTU_OP) begin
            hi_q <= prod_u[63:32];
            lo_q <= prod_u[31:0];
         end
`endif
      end
   end

   assign stallE = resetn && !flushE && (start || state == BUSY);
   assign hi_o   = hi_q;
   assign lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Directed bench for muldiv_hilo: vector table plus flush/reset sequences.
// Covers both builds through MULDIV_ITER_MULT_EN.
module tb_muldiv_hilo;

   localparam logic [7:0] NOP   = 8'h00;
   localparam logic [7:0] MTHI  = 8'b00010001;
   localparam logic [7:0] MTLO  = 8'b00010011;
   localparam logic [7:0] MULT  = 8'b00011000;
   localparam logic [7:0] MULTU = 8'b00011001;
   localparam logic [7:0] DIV   = 8'b00011010;
   localparam logic [7:0] DIVU  = 8'b00011011;

`ifdef MULDIV_ITER_MULT_EN
   localparam int MUL_CYC = 33;
`else
   localparam int MUL_CYC = 0;
`endif

   logic        clk = 1'b0;
   logic        resetn;
   logic [7:0]  alucontrolE;
   logic        validE, flushE;
   logic [31:0] srcaE, srcbE;
   logic        stallE;
   logic [31:0] hi_o, lo_o;

   int tests = 0;
   int fails = 0;

   muldiv_hilo dut (
      .clk(clk),
      .resetn(resetn),
      .alucontrolE(alucontrolE),
      .validE(validE),
      .flushE(flushE),
      .srcaE(srcaE),
      .srcbE(srcbE),
      .stallE(stallE),
      .hi_o(hi_o),
      .lo_o(lo_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [7:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int          cyc;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t vt[10];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // present op at a negedge, hold it while stalled, return stall count
   task automatic run_op(input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int n);
      alucontrolE = op;
      srcaE       = a;
      srcbE       = b;
      validE      = 1'b1;
      n           = 0;
      #1;
      while (stallE && n < 100) begin
         n++;
         @(negedge clk);
         #1;
      end
      @(negedge clk);
      validE      = 1'b0;
      alucontrolE = NOP;
   endtask

   int n;

   initial begin
      vt[0] = '{"div_neg7_2",   DIV,   32'hFFFF_FFF9, 32'd2,         33, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vt[1] = '{"divu_max_16",  DIVU,  32'hFFFF_FFFF, 32'h10,        33, 32'h0000_000F, 32'h0FFF_FFFF};
      vt[2] = '{"divu_100_7",   DIVU,  32'd100,       32'd7,         33, 32'd2,         32'd14};
      vt[3] = '{"mult_m1_2",    MULT,  32'hFFFF_FFFF, 32'd2,         MUL_CYC, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
      vt[4] = '{"multu_max_2",  MULTU, 32'hFFFF_FFFF, 32'd2,         MUL_CYC, 32'h0000_0001, 32'hFFFF_FFFE};
      vt[5] = '{"div_by_zero",  DIV,   32'h1234,      32'd0,         33, 32'h1234,      32'hFFFF_FFFF};
      vt[6] = '{"divu_by_zero", DIVU,  32'h8000_1234, 32'd0,         33, 32'h8000_1234, 32'hFFFF_FFFF};
      vt[7] = '{"div_min_m1",   DIV,   32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0,         32'h8000_0000};
      vt[8] = '{"div_7_m2",     DIV,   32'd7,         32'hFFFF_FFFE, 33, 32'd1,         32'hFFFF_FFFD};
      vt[9] = '{"mult_min_min", MULT,  32'h8000_0000, 32'h8000_0000, MUL_CYC, 32'h4000_0000, 32'h0};

      resetn      = 1'b0;
      validE      = 1'b0;
      flushE      = 1'b0;
      alucontrolE = NOP;
      srcaE       = 32'b0;
      srcbE       = 32'b0;
      @(negedge clk);
      @(negedge clk);
      check("reset_stall", {31'b0, stallE}, 32'd0);
      check("reset_hi", hi_o, 32'd0);
      check("reset_lo", lo_o, 32'd0);
      resetn = 1'b1;
      @(negedge clk);

      // consecutive entries run back-to-back with no bubble between them
      for (int i = 0; i < 10; i++) begin
         run_op(vt[i].op, vt[i].a, vt[i].b, n);
         check({vt[i].name, "_cyc"}, n, vt[i].cyc);
         check({vt[i].name, "_hi"}, hi_o, vt[i].hi);
         check({vt[i].name, "_lo"}, lo_o, vt[i].lo);
      end

      run_op(MTHI, 32'h1111_1111, 32'h0, n);
      check("mthi_cyc", n, 0);
      run_op(MTLO, 32'h2222_2222, 32'h0, n);
      check("mtlo_cyc", n, 0);
      check("mthi_hi", hi_o, 32'h1111_1111);
      check("mtlo_lo", lo_o, 32'h2222_2222);

      // flush at cycle 10 of a divide
      alucontrolE = DIV;
      srcaE       = 32'd100;
      srcbE       = 32'd7;
      validE      = 1'b1;
      for (int c = 0; c < 10; c++) @(negedge clk);
      flushE = 1'b1;
      #1;
      check("flush_busy_stall", {31'b0, stallE}, 32'd0);
      @(negedge clk);
      flushE = 1'b0;
      validE = 1'b0;
      alucontrolE = NOP;
      #1;
      check("flush_idle_stall", {31'b0, stallE}, 32'd0);
      for (int c = 0; c < 40; c++) @(negedge clk);
      check("flush_busy_hi", hi_o, 32'h1111_1111);
      check("flush_busy_lo", lo_o, 32'h2222_2222);

      // flush in DONE suppresses the write
      alucontrolE = DIVU;
      srcaE       = 32'd100;
      srcbE       = 32'd7;
      validE      = 1'b1;
      n           = 0;
      #1;
      while (stallE && n < 100) begin
         n++;
         @(negedge clk);
         #1;
      end
      check("flush_done_cyc", n, 33);
      flushE = 1'b1;
      @(negedge clk);
      flushE = 1'b0;
      validE = 1'b0;
      alucontrolE = NOP;
      @(negedge clk);
      check("flush_done_hi", hi_o, 32'h1111_1111);
      check("flush_done_lo", lo_o, 32'h2222_2222);

      // flush beats MTHI
      alucontrolE = MTHI;
      srcaE       = 32'hA5A5_A5A5;
      validE      = 1'b1;
      flushE      = 1'b1;
      @(negedge clk);
      flushE = 1'b0;
      validE = 1'b0;
      alucontrolE = NOP;
      @(negedge clk);
      check("flush_mthi_hi", hi_o, 32'h1111_1111);

      // asynchronous reset mid-divide
      run_op(MTHI, 32'hDEAD_BEEF, 32'h0, n);
      run_op(MTLO, 32'hDEAD_BEEF, 32'h0, n);
      check("pre_rst_hi", hi_o, 32'hDEAD_BEEF);
      check("pre_rst_lo", lo_o, 32'hDEAD_BEEF);
      alucontrolE = DIV;
      srcaE       = 32'd100;
      srcbE       = 32'd7;
      validE      = 1'b1;
      for (int c = 0; c < 5; c++) @(negedge clk);
      #2;
      resetn = 1'b0;
      #1;
      check("rst_stall", {31'b0, stallE}, 32'd0);
      check("rst_hi", hi_o, 32'd0);
      check("rst_lo", lo_o, 32'd0);
      validE = 1'b0;
      alucontrolE = NOP;
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      run_op(DIV, 32'hFFFF_FF9C, 32'd7, n);
      check("post_rst_cyc", n, 33);
      check("post_rst_hi", hi_o, 32'hFFFF_FFFE);
      check("post_rst_lo", lo_o, 32'hFFFF_FFF2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
